simon_data_out: RTL
===================

Name: simon_data_out

Overview:
Output packetiser for the SIMON datapath, the transmit-side counterpart of SIMON_dataIN. It accepts processed 2-word result blocks from the cipher core over a 4-phase request/acknowledge handshake. It packs two blocks, or one block when the core marks it last, into a byte-array packet of the same format the input side receives: info byte, count byte, payload. It then presents the packet to the host over a 4-phase ready/acknowledge handshake.

Parameters:
N, 16, SIMON word size in bits; must be a multiple of 8; a block is 2N bits.
INFO_FLAG, 8'h80, OR-ed into the captured info byte to mark a response packet.

Ports:
clk  in  1  clock, all state updates on rising edge
R  in  1  reset, synchronous, active-high
doneDATA  in  1  core has a result block on outDATA (request)
outDATA  in  [1:0][N-1:0]  result block; [1] is the upper word
lastBLK  in  1  sampled with doneDATA; this block closes the packet
infoIN  in  8  info byte of the source packet, sampled with the first block
countIN  in  8  packet sequence count, sampled with the first block
loadOUT  out  1  block captured (acknowledge to core)
readyPKT  out  1  output packet valid
ackPKT  in  1  host has taken the packet
out  out  [(1+N/2):0][7:0]  packet: [1+N/2]=info, [N/2]=count, [N/2-1:0]=payload
busy  out  1  a packet is being assembled or held

Behaviour:
- Reset (R=1 at a rising edge) forces state IDLE and clears everything: loadOUT=0, readyPKT=0, busy=0, out all zero. Reset mid-operation abandons any partial or pending packet with no handshake completion. R has priority over every other input.
- Payload packing: block0 (first block) occupies payload bytes [N/2-1:N/4]; block1 occupies bytes [N/4-1:0]. Within a block, outDATA[1] is in the higher bytes. Bytes are big-endian within each word.
- Info byte = infoIN | INFO_FLAG. Count byte = countIN. Both are sampled at block0 capture and held until the next block0 capture.
- States and transitions:
  - IDLE: busy=0. On doneDATA=1: capture block0, info and count into the out register; set loadOUT=1 the next cycle; go to ACK0.
  - ACK0: loadOUT=1, busy=1. Wait for doneDATA=0, then clear loadOUT.
    - If lastBLK was 1 at capture: zero payload bytes [N/4-1:0] and go to SEND.
    - Otherwise go to WAIT1.
  - WAIT1: busy=1. On doneDATA=1: capture block1 into the low half; set loadOUT=1; go to ACK1. lastBLK is ignored here, since block1 always closes the packet.
  - ACK1: wait for doneDATA=0, then clear loadOUT and go to SEND.
  - SEND: readyPKT=1 and out stable. On ackPKT=1: readyPKT=0 the next cycle; go to REL.
  - REL: wait for ackPKT=0, then go to IDLE.
- Latency:
  - doneDATA rise to loadOUT rise is 1 cycle.
  - doneDATA fall to loadOUT fall is 1 cycle.
  - Final loadOUT fall to readyPKT rise is 1 cycle. readyPKT rises in the same cycle that the state enters SEND.
- doneDATA asserted during SEND or REL is not acknowledged; loadOUT stays 0 and the core stalls until IDLE.
- doneDATA held high in IDLE after a completed packet is treated as a new block0 only once REL has exited.
- ackPKT=1 outside SEND is ignored. ackPKT already high when SEND is entered is taken as the acknowledge on the first SEND cycle.
- out changes only on capture edges or reset. It is never modified while readyPKT=1 or during REL.
- countIN wrap (8'hFF to 8'h00) is passed through unchanged; the block does no arithmetic on count.

Test Plan:
- Reset: hold R=1 two cycles with doneDATA=1 → loadOUT=0, readyPKT=0, busy=0, out=0. Release R → loadOUT=1 one cycle later.
- Two-block packet (N=16): infoIN=8'h01, countIN=8'h05, block0=32'h6565_6877, block1=~block0, lastBLK=0, both 4-phase handshakes → out={8'h81, 8'h05, 8'h65, 8'h65, 8'h68, 8'h77, 8'h9A, 8'h9A, 8'h97, 8'h88}; readyPKT high 1 cycle after the second loadOUT fall; drops 1 cycle after ackPKT=1.
- Single-block packet: block0=32'hC69B_E9BB, lastBLK=1 → payload {C6, 9B, E9, BB, 00, 00, 00, 00}; WAIT1 is never entered.
- Backpressure: doneDATA reasserted while readyPKT=1 and ackPKT held low for 10 cycles → loadOUT stays 0 and out is unchanged. After ackPKT rises then falls, the block returns to IDLE and acknowledges the pending block within 1 cycle.
- Mid-packet reset: R=1 in WAIT1 → all outputs zero next cycle. A following two-block packet with countIN=8'hFF assembles correctly with count byte 8'hFF.
- Early ack: ackPKT already 1 when SEND is entered → readyPKT is high exactly 1 cycle; REL is held until ackPKT=0.

Source files
------------

// File: rtl/simon_data_out_if.sv
// simon_data_out_if: core-side result handshake and host-side packet handshake of the SIMON output packetiser
interface simon_data_out_if #(parameter int N = 16) ();
  logic doneDATA;
  logic [1:0][N-1:0] outDATA;
  logic lastBLK;
  logic [7:0] infoIN;
  logic [7:0] countIN;
  logic loadOUT;
  logic readyPKT;
  logic ackPKT;
  logic [(1+N/2):0][7:0] out;
  logic busy;
  modport master (
    output doneDATA, outDATA, lastBLK, infoIN, countIN, ackPKT,
    input loadOUT, readyPKT, out, busy
  );
  modport slave (
    input doneDATA, outDATA, lastBLK, infoIN, countIN, ackPKT,
    output loadOUT, readyPKT, out, busy
  );
endinterface

// File: rtl/simon_data_out.sv
// simon_data_out: packs one or two 2N-bit result blocks into an info/count/payload packet for the host
module simon_data_out #(
  parameter int N = 16,
  parameter logic [7:0] INFO_FLAG = 8'h80
) (
  input logic clk,
  input logic R,
  simon_data_out_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACK0, WAIT1, ACK1, SEND, REL} state_t;
  state_t state, stateNxt;
  logic loadReg, loadNxt, lastReg, lastNxt;
  logic [(1+N/2):0][7:0] outReg, outNxt;
  always_ff @(posedge clk) begin
    if (R) begin
      state <= IDLE;
      loadReg <= 1'b0;
      lastReg <= 1'b0;
      outReg <= '0;
    end else begin
      state <= stateNxt;
      loadReg <= loadNxt;
      lastReg <= lastNxt;
      outReg <= outNxt;
    end
  end
  // ACK states drop loadOUT first and advance one cycle later, so readyPKT trails the final loadOUT fall by a cycle
  always_comb begin
    stateNxt = state;
    loadNxt = loadReg;
    lastNxt = lastReg;
    outNxt = outReg;
    case (state)
      IDLE: if (bus.doneDATA) begin
        outNxt = {bus.infoIN | INFO_FLAG, bus.countIN, bus.outDATA, {(2*N){1'b0}}};
        lastNxt = bus.lastBLK;
        loadNxt = 1'b1;
        stateNxt = ACK0;
      end
      ACK0: if (loadReg) loadNxt = bus.doneDATA;
            else stateNxt = lastReg ? SEND : WAIT1;
      WAIT1: if (bus.doneDATA) begin
        outNxt[N/4-1:0] = bus.outDATA;
        loadNxt = 1'b1;
        stateNxt = ACK1;
      end
      ACK1: if (loadReg) loadNxt = bus.doneDATA;
            else stateNxt = SEND;
      SEND: stateNxt = bus.ackPKT ? REL : SEND;
      REL: stateNxt = bus.ackPKT ? REL : IDLE;
      default: stateNxt = IDLE;
    endcase
  end
  assign bus.loadOUT = loadReg;
  assign bus.readyPKT = state == SEND;
  assign bus.busy = state != IDLE;
  assign bus.out = outReg;
endmodule
